// File: rtl/fib_seq_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fib_seq_checker: checks an additive (Fibonacci-style) stream that saturates at LIMIT
// Rev 1.0
// ----------------------------------------------------------------------------
module fib_seq_checker #(
  parameter int unsigned W      = 8,
  parameter int unsigned SEED0  = 1,
  parameter int unsigned SEED1  = 1,
  parameter int unsigned LIMIT  = 100,
  parameter int unsigned TARGET = 144,
  parameter int unsigned CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          chk_ok,
  output logic          chk_err,
  output logic [W-1:0]  err_data,
  output logic [W-1:0]  exp_data,
  output logic [CW-1:0] sample_cnt,
  output logic          hit_target,
  output logic [1:0]    state
);

  localparam logic [W-1:0] C_SEED0  = W'(SEED0);
  localparam logic [W-1:0] C_SEED1  = W'(SEED1);
  localparam logic [W-1:0] C_TARGET = W'(TARGET);
  // One extra bit so a LIMIT of 2^W (never saturate) is representable.
  localparam logic [W:0]   C_LIMIT  = (W+1)'(LIMIT);

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_exp;
  logic [W-1:0]  r_err_data;
  logic [CW-1:0] r_cnt;
  logic          r_ok;
  logic          r_err;
  logic          r_hit;

  logic [W-1:0]  w_prev;
  logic [W-1:0]  w_sum;
  logic          w_below;
  logic          w_accept;
  logic          w_match;

  // While in FIRST, r_y still holds SEED1, which is the predecessor of the first sample.
  assign w_prev   = (r_state == ST_FIRST) ? r_y : r_x;
  assign w_sum    = in_data + w_prev;
  assign w_below  = ({1'b0, in_data} < C_LIMIT);
  assign w_accept = in_valid && (r_state != ST_ERR);
  assign w_match  = (in_data == r_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FIRST;
      r_x        <= C_SEED0;
      r_y        <= C_SEED1;
      r_exp      <= C_SEED0;
      r_err_data <= '0;
      r_cnt      <= '0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_hit      <= 1'b0;
    end else begin
      r_ok <= 1'b0;
      if (w_accept) begin
        if (w_match) begin
          r_ok    <= 1'b1;
          r_y     <= w_prev;
          r_x     <= in_data;
          r_exp   <= w_below ? w_sum : in_data;
          r_state <= w_below ? ST_RUN : ST_HOLD;
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (in_data == C_TARGET) begin
            r_hit <= 1'b1;
          end
        end else begin
          r_state    <= ST_ERR;
          r_err      <= 1'b1;
          r_err_data <= in_data;
        end
      end
    end
  end

  assign chk_ok     = r_ok;
  assign chk_err    = r_err;
  assign err_data   = r_err_data;
  assign exp_data   = r_exp;
  assign sample_cnt = r_cnt;
  assign hit_target = r_hit;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_checker.sv
`default_nettype none
// tb_fib_seq_checker: table, directed and randomized checks of fib_seq_checker against a stream model.
module tb_fib_seq_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, b_rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ok, a_err, a_hit, b_ok, b_err, b_hit;
  logic [7:0] a_ed, a_exp, b_ed, b_exp;
  logic [15:0] a_cnt, b_cnt;
  logic [1:0] a_st, b_st;

  fib_seq_checker dut_a (
    .clk(clk), .reset(a_rst), .in_valid(a_valid), .in_data(a_data),
    .chk_ok(a_ok), .chk_err(a_err), .err_data(a_ed), .exp_data(a_exp),
    .sample_cnt(a_cnt), .hit_target(a_hit), .state(a_st)
  );

  fib_seq_checker #(.LIMIT(255)) dut_b (
    .clk(clk), .reset(b_rst), .in_valid(b_valid), .in_data(b_data),
    .chk_ok(b_ok), .chk_err(b_err), .err_data(b_ed), .exp_data(b_exp),
    .sample_cnt(b_cnt), .hit_target(b_hit), .state(b_st)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         started;
    logic [7:0] last;
    logic [7:0] exp;
    int         cnt;
    bit         ok;
    bit         err;
    logic [7:0] errd;
    bit         hit;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.started = 0; m.last = 8'd1; m.exp = 8'd1; m.cnt = 0;
    m.ok = 0; m.err = 0; m.errd = 8'd0; m.hit = 0;
    return m;
  endfunction

  // Expected next value = this + predecessor while below the limit, otherwise repeat.
  function automatic mdl_t step(mdl_t m, bit v, logic [7:0] d, int lim);
    mdl_t n = m;
    int prev;
    n.ok = 0;
    if (v && !m.err) begin
      if (d == m.exp) begin
        prev = m.started ? int'(m.last) : 1;
        n.ok = 1;
        n.exp = (int'(d) < lim) ? 8'((int'(d) + prev) % 256) : d;
        n.last = d;
        n.started = 1;
        if (n.cnt < 65535) n.cnt++;
        if (d == 8'd144) n.hit = 1;
      end else begin
        n.err = 1;
        n.errd = d;
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] mstate(mdl_t m, int lim);
    if (m.err) return 2'd3;
    if (!m.started) return 2'd0;
    if (int'(m.last) >= lim) return 2'd2;
    return 2'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input mdl_t m, input int lim,
                         input logic ok, input logic err, input logic [7:0] ed,
                         input logic [7:0] ex, input logic [15:0] cnt,
                         input logic hit, input logic [1:0] st);
    chk({tag, " chk_ok"}, ok, m.ok);
    chk({tag, " chk_err"}, err, m.err);
    chk({tag, " err_data"}, ed, m.errd);
    chk({tag, " exp_data"}, ex, m.exp);
    chk({tag, " sample_cnt"}, cnt, m.cnt);
    chk({tag, " hit_target"}, hit, m.hit);
    chk({tag, " state"}, st, mstate(m, lim));
  endtask

  task automatic cmp_both(input string tag);
    cmp_all({"A ", tag}, ma, 100, a_ok, a_err, a_ed, a_exp, a_cnt, a_hit, a_st);
    cmp_all({"B ", tag}, mb, 255, b_ok, b_err, b_ed, b_exp, b_cnt, b_hit, b_st);
  endtask

  task automatic cyc(input bit va, input logic [7:0] da, input bit vb, input logic [7:0] db,
                     input string tag);
    a_valid = va; a_data = da; b_valid = vb; b_data = db;
    @(posedge clk);
    #1;
    ma = step(ma, va, da, 100);
    mb = step(mb, vb, db, 255);
    cmp_both(tag);
  endtask

  // Reset is pulsed between clock edges so the clearing can only be asynchronous.
  task automatic do_reset(input bit ra, input bit rb, input string tag);
    if (ra) a_rst = 1'b1;
    if (rb) b_rst = 1'b1;
    #2;
    if (ra) ma = mdl_reset();
    if (rb) mb = mdl_reset();
    cmp_both(tag);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         ok;
    logic [1:0] st;
    logic [7:0] ex;
    int         cnt;
    bit         hit;
  } vec_t;

  vec_t tbl[15];
  logic [7:0] fib[13];
  logic [7:0] fibb[13];

  initial begin
    tbl[0]  = '{1, 8'd1,   1, 2'd1, 8'd2,   1,  0};
    tbl[1]  = '{1, 8'd2,   1, 2'd1, 8'd3,   2,  0};
    tbl[2]  = '{1, 8'd3,   1, 2'd1, 8'd5,   3,  0};
    tbl[3]  = '{0, 8'd99,  0, 2'd1, 8'd5,   3,  0};
    tbl[4]  = '{1, 8'd5,   1, 2'd1, 8'd8,   4,  0};
    tbl[5]  = '{1, 8'd8,   1, 2'd1, 8'd13,  5,  0};
    tbl[6]  = '{1, 8'd13,  1, 2'd1, 8'd21,  6,  0};
    tbl[7]  = '{1, 8'd21,  1, 2'd1, 8'd34,  7,  0};
    tbl[8]  = '{1, 8'd34,  1, 2'd1, 8'd55,  8,  0};
    tbl[9]  = '{1, 8'd55,  1, 2'd1, 8'd89,  9,  0};
    tbl[10] = '{1, 8'd89,  1, 2'd1, 8'd144, 10, 0};
    tbl[11] = '{1, 8'd144, 1, 2'd2, 8'd144, 11, 1};
    tbl[12] = '{1, 8'd144, 1, 2'd2, 8'd144, 12, 1};
    tbl[13] = '{1, 8'd144, 1, 2'd2, 8'd144, 13, 1};
    tbl[14] = '{0, 8'd7,   0, 2'd2, 8'd144, 13, 1};
    fib  = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd144, 8'd144};
    fibb = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    ma = mdl_reset();
    mb = mdl_reset();

    repeat (2) @(posedge clk);
    #1;
    do_reset(1, 1, "reset");

    // Clean stream on A, hand-computed expectations from the table.
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].v, tbl[i].d, 0, 8'($urandom), "tbl");
      chk("tbl chk_ok", a_ok, tbl[i].ok);
      chk("tbl state", a_st, tbl[i].st);
      chk("tbl exp_data", a_exp, tbl[i].ex);
      chk("tbl sample_cnt", a_cnt, tbl[i].cnt);
      chk("tbl hit_target", a_hit, tbl[i].hit);
      chk("tbl chk_err", a_err, 0);
    end

    // Same stream with two idle cycles between samples.
    do_reset(1, 0, "gap reset");
    for (int i = 0; i < 13; i++) begin
      cyc(1, fib[i], 0, 8'd0, "gap v");
      cyc(0, 8'($urandom), 0, 8'd0, "gap idle");
      cyc(0, 8'($urandom), 0, 8'd0, "gap idle");
    end
    chk("gap final exp", a_exp, 144);
    chk("gap final cnt", a_cnt, 13);
    chk("gap final st", a_st, 2);

    // 1,2,4: mismatch at 4, then an otherwise-valid 3 is ignored.
    do_reset(1, 0, "e124 reset");
    cyc(1, 8'd1, 0, 8'd0, "e124");
    cyc(1, 8'd2, 0, 8'd0, "e124");
    cyc(1, 8'd4, 0, 8'd0, "e124");
    chk("e124 err", a_err, 1);
    chk("e124 st", a_st, 3);
    chk("e124 err_data", a_ed, 4);
    chk("e124 exp", a_exp, 3);
    chk("e124 cnt", a_cnt, 2);
    cyc(1, 8'd3, 0, 8'd0, "e124 post");
    chk("e124 post cnt", a_cnt, 2);
    chk("e124 post ok", a_ok, 0);

    // First sample wrong.
    do_reset(1, 0, "e7 reset");
    cyc(1, 8'd7, 0, 8'd0, "e7");
    chk("e7 err_data", a_ed, 7);
    chk("e7 cnt", a_cnt, 0);
    chk("e7 exp", a_exp, 1);
    chk("e7 st", a_st, 3);

    // Reset in RUN, then the release-cycle sample is judged against SEED0.
    do_reset(1, 0, "mid reset0");
    cyc(1, 8'd1, 0, 8'd0, "mid");
    cyc(1, 8'd2, 0, 8'd0, "mid");
    cyc(1, 8'd3, 0, 8'd0, "mid");
    chk("mid pre st", a_st, 1);
    a_rst = 1'b1;
    #2;
    chk("mid async cnt", a_cnt, 0);
    chk("mid async exp", a_exp, 1);
    chk("mid async st", a_st, 0);
    ma = mdl_reset();
    a_rst = 1'b0;
    cyc(1, 8'd1, 0, 8'd0, "mid after");
    cyc(1, 8'd2, 0, 8'd0, "mid after");
    chk("mid after cnt", a_cnt, 2);
    chk("mid after ok", a_ok, 1);

    // Wrap-around on the LIMIT=255 instance.
    for (int i = 0; i < 13; i++) cyc(0, 8'd0, 1, fibb[i], "wrap");
    chk("wrap exp", b_exp, 98);
    chk("wrap err", b_err, 0);
    chk("wrap cnt", b_cnt, 13);

    // Randomized streams, mostly following the expected value.
    for (int i = 0; i < 1500; i++) begin
      bit va, vb;
      logic [7:0] da, db;
      if ($urandom % 40 == 0) do_reset(1, 0, "rnd reset");
      if ($urandom % 40 == 0) do_reset(0, 1, "rnd reset");
      va = ($urandom % 4) != 0;
      vb = ($urandom % 4) != 0;
      da = (($urandom % 8) != 0) ? ma.exp : 8'($urandom);
      db = (($urandom % 8) != 0) ? mb.exp : 8'($urandom);
      cyc(va, da, vb, db, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
